// File: rtl/history_scan.sv
// history_scan: walks the active area of a camera frame in raster order. It
// issues a history-RAM read for each accepted pixel and presents that pixel's
// address, coordinates, chroma and stored color history one cycle later.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   VGA_VS                vertical sync; its falling edge starts a frame
//   pixel_valid           one pixel per asserted cycle
//   Cb_in, Cr_in          chroma of the strobed pixel
//   mem_raddr             history-RAM read address (combinational, RAM has 1-cycle latency)
//   mem_rdata             history-RAM read data
//   wr_we/wr_addr/wr_data mirror of the history write port (used only for bypass)
//   read_addr/x/y, Cb, Cr presented pixel address, coordinates and chroma
//   color_history         stored history of the presented pixel
//   color_valid           one-cycle qualifier for the presented-pixel outputs
//   frame_done            one-cycle pulse after the last pixel is accepted
//   overrun               sticky: a pixel strobe arrived outside a scan
//
// Optional feature: define HISTORY_BYPASS_EN to forward in-flight history
// writes to color_history.
module history_scan #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        VGA_VS,
  input  logic        pixel_valid,
  input  logic [7:0]  Cb_in,
  input  logic [7:0]  Cr_in,
  output logic [18:0] mem_raddr,
  input  logic [3:0]  mem_rdata,
  input  logic        wr_we,
  input  logic [18:0] wr_addr,
  input  logic [3:0]  wr_data,
  output logic [18:0] read_addr,
  output logic [9:0]  read_x,
  output logic [9:0]  read_y,
  output logic [7:0]  Cb,
  output logic [7:0]  Cr,
  output logic [3:0]  color_history,
  output logic        color_valid,
  output logic        frame_done,
  output logic        overrun
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 10;
  localparam int unsigned AW = 19;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state_q, state_d;
  logic          vs_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    hist_q;
  logic          vs_fall_c;
  logic          last_c;
  logic          accept_c;

  assign vs_fall_c = vs_q & ~VGA_VS;
  assign last_c    = (x_q == XW'(H_ACTIVE - 1)) && (y_q == YW'(V_ACTIVE - 1));
  assign mem_raddr = addr_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and pixel acceptance; a frame-start edge beats any strobe
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    if (vs_fall_c) begin
      state_d = SCAN;
    end else begin
      case (state_q)
        SCAN: begin
          if (pixel_valid) begin
            accept_c = 1'b1;
            if (last_c) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Raster counters, sync edge detect, overrun and presentation registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      read_addr   <= '0;
      read_x      <= '0;
      read_y      <= '0;
      Cb          <= '0;
      Cr          <= '0;
      hist_q      <= '0;
      color_valid <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      vs_q        <= VGA_VS;
      color_valid <= accept_c;
      frame_done  <= accept_c & last_c;
      if (vs_fall_c) begin
        x_q     <= '0;
        y_q     <= '0;
        addr_q  <= '0;
        overrun <= 1'b0;
      end else begin
        if (pixel_valid && state_q != SCAN) overrun <= 1'b1;
        // Counters hold at the final pixel; addr tracks y*H_ACTIVE+x incrementally
        if (accept_c && !last_c) begin
          addr_q <= addr_q + AW'(1);
          if (x_q == XW'(H_ACTIVE - 1)) begin
            x_q <= '0;
            y_q <= y_q + YW'(1);
          end else begin
            x_q <= x_q + XW'(1);
          end
        end
      end
      if (accept_c) begin
        read_addr <= addr_q;
        read_x    <= x_q;
        read_y    <= y_q;
        Cb        <= Cb_in;
        Cr        <= Cr_in;
      end
      // Keep the presented history so color_history holds between pixels
      if (color_valid) hist_q <= color_history;
    end
  end

`ifdef HISTORY_BYPASS_EN
  logic       byp_hit_q;
  logic [3:0] byp_data_q;

  // Capture a write that hits the address being read in the issuing cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else if (accept_c) begin
      byp_hit_q  <= wr_we && (wr_addr == addr_q);
      byp_data_q <= wr_data;
    end
  end

  // Newest write wins: presenting-cycle hit, then issuing-cycle hit, then RAM
  always_comb begin
    color_history = hist_q;
    if (color_valid) begin
      if (wr_we && (wr_addr == read_addr)) color_history = wr_data;
      else if (byp_hit_q)                  color_history = byp_data_q;
      else                                 color_history = mem_rdata;
    end
  end
`else
  logic unused_wr_c;
  assign unused_wr_c = ^{wr_we, wr_addr, wr_data};

  // RAM data arrives in the presenting cycle
  always_comb begin
    color_history = hist_q;
    if (color_valid) color_history = mem_rdata;
  end
`endif

endmodule

// File: doc/history_scan.md
HISTORY_SCAN -- requirements
Module: history_scan

Interface
REQ-001 Parameter H_ACTIVE, 640: active pixels per line.
REQ-002 Parameter V_ACTIVE, 480: active lines per frame.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 VGA_VS  in  1  vertical sync; its falling edge marks frame start.
REQ-006 pixel_valid  in  1  camera pixel strobe, one pixel per asserted cycle.
REQ-007 Cb_in, Cr_in  in  8 each  chroma of the strobed pixel.
REQ-008 mem_raddr  out  19  history-RAM read address; RAM returns data one cycle later.
REQ-009 mem_rdata  in  4  history-RAM read data.
REQ-010 wr_we, wr_addr, wr_data  in  1/19/4  history write port mirror from the color detector, used for bypass.
REQ-011 read_addr, read_x, read_y  out  19/10/10  address and coordinates of the presented pixel.
REQ-012 Cb, Cr  out  8 each  chroma of the presented pixel.
REQ-013 color_history  out  4  stored history of the presented pixel.
REQ-014 color_valid  out  1  one-cycle qualifier for all presented-pixel outputs.
REQ-015 frame_done  out  1  one-cycle pulse after the last pixel is accepted.
REQ-016 overrun  out  1  sticky flag: a pixel strobe arrived outside SCAN.

Function
REQ-017 States SHALL be IDLE, SCAN and DONE.
REQ-018 A VS falling edge SHALL be detected from a registered copy of VGA_VS, with a one-cycle detection delay.
REQ-019 In any state, a VS falling edge SHALL force SCAN with x=0, y=0, addr=0, and SHALL clear overrun, including when it arrives mid-frame.
REQ-020 A pixel is accepted only in SCAN with pixel_valid=1; if this coincides with a VS falling edge, the edge SHALL win and the pixel SHALL be dropped.
REQ-021 Acceptance SHALL drive x+1; at x=H_ACTIVE-1, x wraps to 0 and y increments.
REQ-022 addr SHALL be held as an incremental counter, +1 per accepted pixel, with no multiplier, and SHALL always equal y*H_ACTIVE+x.
REQ-023 mem_raddr SHALL equal the current addr combinationally.
REQ-024 Acceptance at x=H_ACTIVE-1, y=V_ACTIVE-1 SHALL transition SCAN->DONE and pulse frame_done on the next cycle; counters SHALL hold at the last pixel.
REQ-025 pixel_valid in IDLE or DONE SHALL be ignored for the datapath and SHALL set overrun.
REQ-026 Latency SHALL be one cycle: for an accepted pixel at cycle t, color_valid=1 at t+1, with read_addr/x/y/Cb/Cr registered from cycle t and color_history=mem_rdata.
REQ-027 color_valid SHALL be 0 in every cycle not following an acceptance; the other outputs hold their last values.
REQ-028 Back-to-back acceptances SHALL yield back-to-back color_valid with no bubbles.

Reset
REQ-029 Asserting reset_n=0 SHALL immediately force IDLE, and x, y, addr, read_addr, read_x, read_y, Cb, Cr, color_history = 0.
REQ-030 Asserting reset_n=0 SHALL also force color_valid, frame_done, overrun and the registered VGA_VS = 0.
REQ-031 After release, the block SHALL wait in IDLE for a VS falling edge.
REQ-032 Reset asserted mid-frame SHALL discard the in-flight pixel, so no color_valid appears.

Configuration
REQ-033 With macro HISTORY_BYPASS_EN defined, color_history SHALL take the value from the first of these that applies:
  - wr_data, if wr_we=1 and wr_addr==read_addr in the presenting cycle;
  - the captured wr_data, if wr_we=1 and wr_addr==mem_raddr in the issuing cycle;
  - otherwise mem_rdata.
REQ-034 Without HISTORY_BYPASS_EN, color_history SHALL equal mem_rdata unconditionally, and wr_we/wr_addr/wr_data SHALL be unused.

Verification
REQ-035 Reset release, VS 1->0, then 3 strobes → color_valid on 3 consecutive cycles with read_addr 0,1,2, read_x 0,1,2, read_y 0.
REQ-036 Strobe at x=639, y=0 → next presented pixel has read_x=0, read_y=1, read_addr=640.
REQ-037 Full 307200-strobe frame → the last presentation has read_addr=307199, frame_done pulses once, and a further strobe sets overrun=1 with no color_valid.
REQ-038 VS falling edge at x=100, y=50 → the next accepted pixel presents read_addr=0, and overrun clears.
REQ-039 HISTORY_BYPASS_EN defined, mem_rdata=4'b0000, wr_we=1, wr_addr=read_addr, wr_data=4'b1011 in the presenting cycle → color_history=4'b1011; with the macro undefined → 4'b0000.
REQ-040 reset_n dropped one cycle after an acceptance → color_valid stays 0 and all outputs read 0 asynchronously.
